dsp_mem_wctrl: RTL
==================

// Module: dsp_mem_wctrl
// PURPOSE
// - Write-side capture controller for a chain of DSP memory banks (write-clock domain).
// - Drives the bank chain's write-shift data word and write-shift enable.
// - On an armed trigger it shifts exactly one full chain depth of samples into the write
//   registers, then reports done so the scan side can issue read-update / read-shift.
// - Sits between the DSP datapath tap and the first bank's data input.
// PARAMETERS
// - MemWidth   default `MEM_WIDTH   sample word width.
// - BankDepth  default `BANK_DEPTH  words per bank.
// - NumBanks   default 4            banks chained in series.
// - PostDepth  default 16           words captured after the trigger; DSP_MEM_WCTRL_PRETRIG_EN only.
// - Derived: TotalDepth = NumBanks*BankDepth; CntWidth = $clog2(TotalDepth+1).
// PORTS
// - i_wclk              in   1         write clock.
// - rst_sync_write      in   1         asynchronous reset, active-high, already synchronized to i_wclk.
// - i_arm               in   1         level; high = armed, low = return to idle.
// - i_trig              in   1         trigger level; rising edge is detected internally.
// - i_dat               in   MemWidth  sample from the DSP tap; valid every cycle.
// - o_dat_bank_mem      out  MemWidth  to first bank data input.
// - o_cfg_mode_wshift   out  1         to all banks' write-shift mode.
// - o_busy              out  1         high in ARMED/CAPTURE/FLUSH.
// - o_done              out  1         capture complete; memory is stable.
// - o_cnt               out  CntWidth  words shifted in the current capture.
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; trigger-edge register 0.
//   Reset mid-capture aborts the capture; the bank contents are undefined (the banks reset separately).
// - All outputs are registered.
// - o_dat_bank_mem = i_dat delayed by 1 cycle, free-running in every state.
// - Timing: the bank registers the write-shift mode 1 cycle before shifting.
//   With the trigger edge detected at edge T:
//   - o_cfg_mode_wshift rises after T.
//   - The banks shift at edges T+2 .. T+TotalDepth+1.
//   - The first stored word is i_dat sampled at edge T+1.
// - FSM:
//   - IDLE: i_arm=1 -> ARMED.
//   - ARMED: rising edge of i_trig (trig & ~trig_q) -> CAPTURE with o_cnt=0. i_arm=0 -> IDLE.
//     A trigger that is already high when arming does not fire; a new edge is required.
//   - CAPTURE: o_cfg_mode_wshift=1; o_cnt increments each cycle.
//     When o_cnt reaches TotalDepth-1 -> FLUSH. The trigger is ignored. i_arm=0 -> IDLE with wshift=0 (abort).
//   - FLUSH: o_cfg_mode_wshift=0 for 1 cycle, covering the last bank shift -> DONE.
//   - DONE: o_done=1, o_cnt held at TotalDepth. i_arm=0 -> IDLE and clears o_done.
// - o_cfg_mode_wshift is high for exactly TotalDepth consecutive cycles per capture.
// - o_cnt saturates at TotalDepth; it never wraps.
// - Arm and trigger edge in the same cycle while in IDLE: go to ARMED only; the edge is not consumed.
// CONFIGURATION
// - Macro DSP_MEM_WCTRL_PRETRIG_EN.
// - Defined (pre-trigger ring mode):
//   - ARMED drives o_cfg_mode_wshift=1 continuously, so the chain holds rolling history.
//   - The trigger edge loads o_cnt=TotalDepth-PostDepth and enters CAPTURE; the capture then runs to
//     TotalDepth as normal.
//   - The memory holds TotalDepth-PostDepth pre-trigger words.
//   - Compile-time check: PostDepth must be in 1..TotalDepth.
// - Undefined: the ARMED state holds wshift=0; PostDepth is unused; the full depth is post-trigger.
// STRUCTURE
// - Shared package dsp_mem_pkg:
//   - typedef enum logic [2:0] dsp_mem_wstate_e {IDLE, ARMED, CAPTURE, FLUSH, DONE}.
//   - localparams MEM_WIDTH and BANK_DEPTH, mirroring the macros.
//   - function dsp_mem_total_depth(num_banks).
// - One sub-module: dsp_trig_edge. A 1-flop rising-edge detector on i_wclk with asynchronous reset;
//   it is also reused by the read-side controller.
// TESTING
// - Config: MemWidth=8, BankDepth=4, NumBanks=2 (TotalDepth=8), PostDepth=3, 1-bank-pair chain model.
// - Reset then idle:
//   - Stimulus: release reset, hold i_arm=0, toggle i_trig.
//   - Required: all outputs stay 0; o_dat_bank_mem follows i_dat after 1 cycle.
// - Basic capture:
//   - Stimulus: i_dat=ramp 0x00,0x01..., arm, trigger edge at T.
//   - Required: wshift is high for 8 cycles; o_done=1 at T+10; the chain holds the ramp words
//     starting at the sample from T+1; o_cnt=8.
// - Pre-armed trigger:
//   - Stimulus: i_trig=1 before arm.
//   - Required: no capture until i_trig falls and rises again.
// - Abort:
//   - Stimulus: drop i_arm at o_cnt=3.
//   - Required: the next cycle is IDLE; wshift=0; o_done never asserts.
// - Reset mid-capture:
//   - Stimulus: assert rst_sync_write at o_cnt=5.
//   - Required: all outputs 0 immediately (asynchronous); the next arm and trigger capture normally.
// - DSP_MEM_WCTRL_PRETRIG_EN defined:
//   - Stimulus: ramp input, arm, trigger at sample 0x20.
//   - Required: wshift runs continuously while armed, then for 3 more cycles after the edge;
//     the memory holds 5 pre-trigger and 3 post-trigger words.

Source files
------------

// File: rtl/dsp_mem_pkg.sv
// Shared types and defaults for the DSP memory bank write/read controllers.
// MEM_WIDTH / BANK_DEPTH macros set the default sample width and bank depth.
`ifndef MEM_WIDTH
`define MEM_WIDTH 8
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 16
`endif

package dsp_mem_pkg;

    localparam int MEM_WIDTH  = `MEM_WIDTH;
    localparam int BANK_DEPTH = `BANK_DEPTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } dsp_mem_wstate_e;

    function automatic int dsp_mem_total_depth(input int num_banks, input int bank_depth = BANK_DEPTH);
        return num_banks * bank_depth;
    endfunction

endpackage

// File: rtl/dsp_mem_wctrl_trig_edge.sv
// Single-flop rising-edge detector on the write clock; shared with the read-side controller.
module dsp_trig_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_d;
    logic sig_q;

    // next value of the history flop
    always_comb begin
        sig_d = i_sig;
    end

    // history flop, cleared by the asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/dsp_mem_wctrl.sv
// Write-side capture controller feeding a chain of DSP memory banks.
// Optional pre-trigger ring mode is enabled by defining DSP_MEM_WCTRL_PRETRIG_EN.
module dsp_mem_wctrl
    import dsp_mem_pkg::*;
#(
    parameter  int MemWidth   = MEM_WIDTH,
    parameter  int BankDepth  = BANK_DEPTH,
    parameter  int NumBanks   = 4,
    parameter  int PostDepth  = 16,
    localparam int TotalDepth = dsp_mem_total_depth(NumBanks, BankDepth),
    localparam int CntWidth   = $clog2(TotalDepth + 1)
) (
    input  logic                i_wclk,
    input  logic                rst_sync_write,
    input  logic                i_arm,
    input  logic                i_trig,
    input  logic [MemWidth-1:0] i_dat,
    output logic [MemWidth-1:0] o_dat_bank_mem,
    output logic                o_cfg_mode_wshift,
    output logic                o_busy,
    output logic                o_done,
    output logic [CntWidth-1:0] o_cnt
);

`ifdef DSP_MEM_WCTRL_PRETRIG_EN
    localparam bit PretrigEn = 1'b1;
`else
    localparam bit PretrigEn = 1'b0;
`endif

    if (PretrigEn && (PostDepth < 1 || PostDepth > TotalDepth)) begin : g_postdepth_chk
        $error("dsp_mem_wctrl: PostDepth must lie in 1..TotalDepth");
    end

    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TotalDepth - 1);
    localparam logic [CntWidth-1:0] CntFull  = CntWidth'(TotalDepth);
    localparam logic [CntWidth-1:0] CntStart = PretrigEn ? CntWidth'(TotalDepth - PostDepth)
                                                         : {CntWidth{1'b0}};

    dsp_mem_wstate_e     state_d, state_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic [MemWidth-1:0] dat_d, dat_q;
    logic                wshift_d, wshift_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                trig_rise;

    dsp_trig_edge u_trig_edge (
        .i_clk  (i_wclk),
        .i_rst  (rst_sync_write),
        .i_sig  (i_trig),
        .o_rise (trig_rise)
    );

    // capture FSM; wshift is computed one cycle ahead because the banks register the mode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wshift_d = 1'b0;
        done_d   = 1'b0;
        dat_d    = i_dat;
        case (state_q)
            IDLE: begin
                cnt_d = {CntWidth{1'b0}};
                if (i_arm) begin
                    state_d  = ARMED;
                    wshift_d = PretrigEn;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (!i_arm) begin
                    state_d = IDLE;
                end else if (trig_rise) begin
                    state_d  = CAPTURE;
                    cnt_d    = CntStart;
                    wshift_d = 1'b1;
                end else begin
                    wshift_d = PretrigEn;
                end
            end
            CAPTURE: begin
                if (!i_arm) begin
                    state_d = IDLE;
                    cnt_d   = {CntWidth{1'b0}};
                end else if (cnt_q == CntLast) begin
                    state_d = FLUSH;
                    cnt_d   = CntFull;
                end else begin
                    cnt_d    = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
                    wshift_d = 1'b1;
                end
            end
            FLUSH: begin
                // the banks still perform their last shift during this cycle
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                if (!i_arm) begin
                    state_d = IDLE;
                    cnt_d   = {CntWidth{1'b0}};
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CntWidth{1'b0}};
            end
        endcase
        busy_d = (state_d == ARMED) || (state_d == CAPTURE) || (state_d == FLUSH);
    end

    // state and registered outputs
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            state_q  <= IDLE;
            cnt_q    <= {CntWidth{1'b0}};
            dat_q    <= {MemWidth{1'b0}};
            wshift_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            wshift_q <= wshift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_dat_bank_mem    = dat_q;
    assign o_cfg_mode_wshift = wshift_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_cnt             = cnt_q;

endmodule
